fetch_queue_unit: RTL and testbench

- Parametrised instruction-fetch stage that replaces the single PC register and PC mux in front of the instruction memory.
- Holds the fetch PC and issues requests to a synchronous-read instruction memory (1-cycle latency).
- Buffers returned instructions with their PCs in a DEPTH-entry queue, presented to the ID stage over a valid/ready handshake.
- Handles external PC load, branch/jump redirect with flush, and back-pressure from decode.

---
 rtl/fetch_queue_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_queue_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: fetch PC, 1-cycle synchronous imem requests and a DEPTH-entry instruction queue.
// Optional performance counters are enabled with `define FETCH_QUEUE_PERF_EN.
module fetch_queue_unit #(
  parameter int unsigned           XLEN     = 32,
  parameter int unsigned           IMEM_AW  = 11,
  parameter int unsigned           DEPTH    = 4,
  parameter logic [XLEN-1:0]       RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               PC_set,
  input  logic [XLEN-1:0]    PC,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [XLEN-1:0]    id_instr,
  output logic [XLEN-1:0]    id_pc,
  output logic [XLEN-1:0]    id_pc_incr4
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed,
  output logic [31:0]        perf_starve
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic              run_q;
  logic              inflight_q;
  logic [XLEN-1:0]   fetch_pc_q;
  logic [XLEN-1:0]   req_pc_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [XLEN-1:0]   instr_mem [DEPTH];
  logic [XLEN-1:0]   pc_mem    [DEPTH];
  logic [XLEN-1:0]   hold_instr_q;
  logic [XLEN-1:0]   hold_pc_q;

  logic              flush_c;
  logic              push_c;
  logic              pop_c;
  logic              empty_c;
  logic [XLEN-1:0]   head_instr_c;
  logic [XLEN-1:0]   head_pc_c;

  assign flush_c   = PC_set | redirect_valid;
  assign push_c    = inflight_q & ~flush_c;
  assign empty_c   = (count_q == '0);
  assign id_valid  = ~empty_c | push_c;
  assign pop_c     = id_valid & id_ready & ~flush_c;
  assign imem_req  = run_q & ~flush_c &
                     ((count_q + CNT_W'(inflight_q)) < CNT_W'(DEPTH));
  assign imem_addr = fetch_pc_q[IMEM_AW+1:2];

  // An empty queue passes the arriving response straight through so a redirect
  // target is visible two cycles after the flush; otherwise the last head is held.
  always_comb begin
    head_instr_c = hold_instr_q;
    head_pc_c    = hold_pc_q;
    if (!empty_c) begin
      head_instr_c = instr_mem[rd_ptr_q];
      head_pc_c    = pc_mem[rd_ptr_q];
    end else if (push_c) begin
      head_instr_c = imem_rdata;
      head_pc_c    = req_pc_q;
    end
  end

  assign id_instr    = head_instr_c;
  assign id_pc       = head_pc_c;
  assign id_pc_incr4 = head_pc_c + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= imem_req;
      if (PC_set)              fetch_pc_q <= PC & ~XLEN'(3);
      else if (redirect_valid) fetch_pc_q <= redirect_pc & ~XLEN'(3);
      else if (imem_req)       fetch_pc_q <= fetch_pc_q + XLEN'(4);
      if (imem_req) req_pc_q <= fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_c) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= req_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else if (id_valid) begin
      hold_instr_q <= head_instr_c;
      hold_pc_q    <= head_pc_c;
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  // Flushed count covers queued entries plus the response still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
      perf_starve  <= '0;
    end else begin
      if (push_c)  perf_fetched <= perf_fetched + 32'd1;
      if (flush_c) perf_flushed <= perf_flushed + 32'(count_q) + 32'(inflight_q);
      if (id_ready && !id_valid && run_q) perf_starve <= perf_starve + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: vector table from reset release plus scoreboarded redirect sequences.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_set;
  logic [31:0] pc_val;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [10:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_incr4;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched, perf_flushed, perf_starve;
`endif

  fetch_queue_unit dut (
    .clk(clk), .rst_n(rst_n), .PC_set(pc_set), .PC(pc_val),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_incr4(id_pc_incr4)
`ifdef FETCH_QUEUE_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed), .perf_starve(perf_starve)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory: word address times 0x11.
  always @(posedge clk) if (imem_req) imem_rdata <= 32'(imem_addr) * 32'h11;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] sb[$];
  logic sb_on = 1'b0;
  logic watch100 = 1'b0;
  logic bad_fetch = 1'b0;

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return ((pc >> 2) & 32'h7FF) * 32'h11;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin cyc(); n++; end
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d expected entries never delivered", sb.size());
      sb.delete();
    end
    sb_on = 1'b0;
  endtask

  // Scoreboard consumer: every accepted head must match the next expected PC.
  always @(negedge clk) begin
    if (sb_on && rst_n && id_valid && id_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL sb_extra: id_pc=%h accepted with no expected entry", id_pc);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("sb_pc", id_pc, e);
        chk("sb_instr", id_instr, exp_instr(e));
        chk("sb_incr4", id_pc_incr4, e + 32'd4);
      end
    end
  end

  always @(negedge clk) if (watch100 && imem_req && imem_addr == 11'h040) bad_fetch <= 1'b1;

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        rdy;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;
  vec_t vt[21];

  function automatic vec_t mk(input logic r, input logic q, input logic v, input logic [31:0] p);
    vec_t x;
    x.rdy = r; x.e_req = q; x.e_valid = v; x.e_pc = p;
    return x;
  endfunction

  initial begin
    // Cycle 0 is the cycle in which rst_n rises.
    vt[0] = mk(1, 0, 0, 32'h0);  vt[1] = mk(1, 1, 0, 32'h0);
    vt[2] = mk(1, 1, 1, 32'h0);  vt[3] = mk(1, 1, 1, 32'h4);
    vt[4] = mk(1, 1, 1, 32'h8);
    vt[5] = mk(0, 1, 1, 32'hC);  vt[6] = mk(0, 1, 1, 32'hC);
    vt[7] = mk(0, 1, 1, 32'hC);
    for (int i = 8; i < 15; i++) vt[i] = mk(0, 0, 1, 32'hC);
    vt[15] = mk(1, 0, 1, 32'hC);
    for (int i = 16; i < 21; i++) vt[i] = mk(1, 1, 1, 32'h10 + 32'(i - 16) * 32'd4);

    rst_n = 1'b0; pc_set = 1'b0; pc_val = '0; redirect_valid = 1'b0;
    redirect_pc = '0; id_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_incr4", id_pc_incr4, 32'd4);
    cyc();
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      id_ready = vt[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vt[i].e_req));
      chk($sformatf("vec%0d_valid", i), 32'(id_valid), 32'(vt[i].e_valid));
      chk($sformatf("vec%0d_pc", i), id_pc, vt[i].e_pc);
      chk($sformatf("vec%0d_instr", i), id_instr, exp_instr(vt[i].e_pc));
      chk($sformatf("vec%0d_incr4", i), id_pc_incr4, vt[i].e_pc + 32'd4);
      cyc();
    end

    // Fill the queue, then redirect while full (pop in the flush cycle is ignored).
    id_ready = 1'b0;
    repeat (8) cyc();
    @(negedge clk);
    chk("full_valid", 32'(id_valid), 32'd1);
    chk("full_noreq", 32'(imem_req), 32'd0);
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h200; id_ready = 1'b1;
    @(negedge clk);
    chk("flush_noreq", 32'(imem_req), 32'd0);
    cyc();
    redirect_valid = 1'b0;
    sb.push_back(32'h200); sb.push_back(32'h204); sb.push_back(32'h208);
    sb_on = 1'b1;
    @(negedge clk);
    chk("redir_t1_valid", 32'(id_valid), 32'd0);
    chk("redir_t1_req", 32'(imem_req), 32'd1);
    chk("redir_t1_addr", 32'(imem_addr), 32'h80);
    cyc();
    @(negedge clk);
    chk("redir_t2_valid", 32'(id_valid), 32'd1);
    chk("redir_t2_pc", id_pc, 32'h200);
    drain();

    // PC_set beats redirect; PC_set held for three cycles reloads and blocks issue.
    cyc();
    pc_set = 1'b1; pc_val = 32'h403; redirect_valid = 1'b1; redirect_pc = 32'h100;
    watch100 = 1'b1;
    @(negedge clk);
    chk("pcset_noreq0", 32'(imem_req), 32'd0);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("pcset_noreq1", 32'(imem_req), 32'd0);
    cyc();
    @(negedge clk);
    chk("pcset_noreq2", 32'(id_valid), 32'd0);
    cyc();
    pc_set = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back(32'h400 + 32'(i) * 32'd4);
    sb_on = 1'b1;
    @(negedge clk);
    chk("pcset_addr", 32'(imem_addr), 32'h100);
    drain();
    watch100 = 1'b0;
    chk("never_0x100", 32'(bad_fetch), 32'd0);

    // PC wrap at 2^32.
    cyc();
    pc_set = 1'b1; pc_val = 32'hFFFF_FFFC;
    cyc();
    pc_set = 1'b0;
    sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0); sb.push_back(32'h4);
    sb_on = 1'b1;
    @(negedge clk);
    chk("wrap_addr0", 32'(imem_addr), 32'h7FF);
    cyc();
    @(negedge clk);
    chk("wrap_req1", 32'(imem_req), 32'd1);
    chk("wrap_addr1", 32'(imem_addr), 32'h0);
    chk("wrap_incr4", id_pc_incr4, 32'h0);
    drain();

    // Asynchronous reset mid-stream with three entries queued or arriving.
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h40; id_ready = 1'b0;
    cyc();
    redirect_valid = 1'b0;
    repeat (3) cyc();
    chk("pre_rst_valid", 32'(id_valid), 32'd1);
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(id_valid), 32'd0);
    chk("async_req", 32'(imem_req), 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1; id_ready = 1'b1;
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
    sb_on = 1'b1;
    @(negedge clk);
    chk("rel_c0_req", 32'(imem_req), 32'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
